flag_unit: RTL and testbench
============================

Name: flag_unit

Overview:
- Processor status-flag register on the consuming side of the ALU flag bus, with flag order {Z, CY, S, P, OV} (bit 4..0).
- Latches ALU output flags and drives them back as the ALU's input flags (carry-in chaining).
- Evaluates branch condition codes for the sequencer.
- Holds a small LIFO flag stack so interrupt entry and return can save and restore status.

Parameters:
- STACK_DEPTH, 4, number of flag-stack entries (power of two, 2..16).
- SP_W, 2, stack pointer width; must equal log2(STACK_DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- alu_flg  input  5  flags from ALU {Z,CY,S,P,OV}.
- flg_upd  input  1  latch alu_flg into the flag register this edge.
- flg_load  input  1  load flg_load_data into the flag register (software write to status).
- flg_load_data  input  5  direct flag value.
- push  input  1  save current flag register onto stack.
- pop  input  1  restore flag register from top of stack.
- cond  input  4  condition code to evaluate.
- flg  output  5  registered flags; feeds ALU in_flg.
- cond_true  output  1  combinational result of cond.
- stack_empty  output  1  stack holds 0 entries.
- stack_full  output  1  stack holds STACK_DEPTH entries.
- stack_err  output  1  one-cycle pulse on an illegal stack operation.

Behaviour:
- Reset (async, immediate): flg=5'b0, stack pointer=0, stack_empty=1, stack_full=0, stack_err=0. Stack storage contents are don't-care.
- Flag register next-value priority, highest first:
  1. Legal pop: top-of-stack value.
  2. flg_load: flg_load_data.
  3. flg_upd: alu_flg.
  4. Otherwise hold.
- Updates are visible on flg one cycle after the edge; latency 1.
- Push:
  - Legal when the stack is not full and pop is low.
  - Writes the pre-edge flg value at the pointer, then pointer +1.
  - A push in the same cycle as flg_upd or flg_load saves the OLD flags, and the register takes the new value.
- Pop:
  - Legal when the stack is not empty and push is low.
  - Pointer -1, and the flag register takes the entry at the new pointer.
- Illegal operations: push when full, pop when empty, or push and pop together.
  - The operation is ignored entirely: no pointer or flag change from the stack.
  - stack_err pulses high for exactly the cycle after the edge.
  - flg_load and flg_upd still apply, since no legal pop is present.
- stack_empty = (count==0) and stack_full = (count==STACK_DEPTH). The counter is SP_W+1 bits wide; there is no wrap-around.
- cond decode (evaluated on flg):
  - 0 always
  - 1 Z
  - 2 !Z
  - 3 CY
  - 4 !CY
  - 5 S
  - 6 !S
  - 7 P
  - 8 !P
  - 9 OV
  - 10 !OV
  - 11 S^OV (signed less)
  - 12 !(S^OV) (signed greater-equal)
  - 13 CY|Z (unsigned lower-same)
  - 14 !(CY|Z) (unsigned higher)
  - 15 never
- No X may propagate to flg from reset. An X on CY from the ALU's pass-through operations is latched only if flg_upd is asserted; the sequencer must not assert flg_upd for those opcodes.

Optional Feature:
- Macro: FLAG_BYPASS_EN.
- Defined: when flg_upd=1 and no legal pop or flg_load is active, cond_true evaluates on alu_flg in the same cycle (forwarding for compare-and-branch back-to-back). flg itself stays registered.
- Undefined: cond_true always evaluates on the registered flg.

Test Plan:
- Reset mid-operation: push twice, assert rst asynchronously between edges -> flg=0, stack_empty=1, stack_err=0 immediately, without waiting for a clock edge.
- Update and condition: alu_flg=5'b01001, flg_upd=1 for one cycle -> next cycle flg=5'b01001; cond=3 gives 1; cond=11 gives 1 (S=0, OV=1); cond=13 gives 1; cond=1 gives 0.
- Push/pop round trip:
  - Load 5'b10000, push, then load 5'b00110 -> flg=00110.
  - Pop -> flg=10000, stack_empty=1.
- Full stack (STACK_DEPTH=4): four pushes -> stack_full=1. Fifth push -> stack_err pulses one cycle, count stays 4. Four pops restore the values in reverse order.
- Simultaneous events:
  - push+pop with 1 entry -> stack_err=1, count unchanged.
  - push+flg_upd(alu_flg=5'b11111) from flg=0 -> stack top=00000, flg=11111.
  - pop on empty with flg_load=5'b00001 -> stack_err=1, flg=00001.
- FLAG_BYPASS_EN: flg=0, flg_upd=1, alu_flg=5'b10000, cond=1 -> cond_true=1 in the same cycle when defined, 0 when undefined.

Source files
------------

// File: rtl/flag_unit_if.sv
// Flag-unit bus: ALU flags in, status-register writes, stack control,
// condition-code select, and the registered flags / status returned.
// master = sequencer/ALU side, slave = flag_unit.
interface flag_unit_if;
    logic [4:0] alu_flg;
    logic       flg_upd;
    logic       flg_load;
    logic [4:0] flg_load_data;
    logic       push;
    logic       pop;
    logic [3:0] cond;
    logic [4:0] flg;
    logic       cond_true;
    logic       stack_empty;
    logic       stack_full;
    logic       stack_err;

    modport master (
        output alu_flg, flg_upd, flg_load, flg_load_data, push, pop, cond,
        input  flg, cond_true, stack_empty, stack_full, stack_err
    );

    modport slave (
        input  alu_flg, flg_upd, flg_load, flg_load_data, push, pop, cond,
        output flg, cond_true, stack_empty, stack_full, stack_err
    );
endinterface

// File: rtl/flag_unit.sv
// flag_unit: processor status-flag register {Z,CY,S,P,OV} (bit 4..0) with
// branch condition evaluation and a LIFO flag stack for interrupt save/restore.
// Optional macro FLAG_BYPASS_EN: forwards alu_flg into the condition
// evaluation in the same cycle when an ALU update is the winning write.
module flag_unit #(
    parameter int STACK_DEPTH = 4,
    parameter int SP_W        = 2
) (
    input  logic        clk,
    input  logic        rst,
    flag_unit_if.slave  bus
);

    localparam logic [SP_W:0] DEPTH_C = (SP_W+1)'(STACK_DEPTH);

    logic [4:0]      flg_q, flg_d;
    logic [SP_W:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [4:0]      mem_q [STACK_DEPTH];

    logic            full, empty;
    logic            push_ok, pop_ok;
    logic [SP_W-1:0] wr_ptr, rd_ptr;
    logic [4:0]      eval_flg;

    // Condition-code decode on a flag vector {Z,CY,S,P,OV}.
    function automatic logic cond_eval(input logic [3:0] c, input logic [4:0] f);
        logic z, cy, s, p, ov;
        z  = f[4];
        cy = f[3];
        s  = f[2];
        p  = f[1];
        ov = f[0];
        case (c)
            4'd0:    cond_eval = 1'b1;
            4'd1:    cond_eval = z;
            4'd2:    cond_eval = !z;
            4'd3:    cond_eval = cy;
            4'd4:    cond_eval = !cy;
            4'd5:    cond_eval = s;
            4'd6:    cond_eval = !s;
            4'd7:    cond_eval = p;
            4'd8:    cond_eval = !p;
            4'd9:    cond_eval = ov;
            4'd10:   cond_eval = !ov;
            4'd11:   cond_eval = s ^ ov;
            4'd12:   cond_eval = !(s ^ ov);
            4'd13:   cond_eval = cy | z;
            4'd14:   cond_eval = !(cy | z);
            default: cond_eval = 1'b0;
        endcase
    endfunction

    assign full    = (cnt_q == DEPTH_C);
    assign empty   = (cnt_q == '0);
    // push and pop together is illegal, so each legal op requires the other low
    assign push_ok = bus.push && !bus.pop && !full;
    assign pop_ok  = bus.pop && !bus.push && !empty;
    assign wr_ptr  = cnt_q[SP_W-1:0];
    assign rd_ptr  = wr_ptr - SP_W'(1);

`ifdef FLAG_BYPASS_EN
    assign eval_flg = (bus.flg_upd && !pop_ok && !bus.flg_load) ? bus.alu_flg : flg_q;
`else
    assign eval_flg = flg_q;
`endif

    // Next flag value (pop > load > ALU update > hold), pointer and error pulse.
    always_comb begin
        flg_d = flg_q;
        if (pop_ok)
            flg_d = mem_q[rd_ptr];
        else if (bus.flg_load)
            flg_d = bus.flg_load_data;
        else if (bus.flg_upd)
            flg_d = bus.alu_flg;

        cnt_d = cnt_q;
        if (push_ok)
            cnt_d = cnt_q + (SP_W+1)'(1);
        else if (pop_ok)
            cnt_d = cnt_q - (SP_W+1)'(1);

        err_d = (bus.push && bus.pop) || (bus.push && full) || (bus.pop && empty);
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flg_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            flg_q <= flg_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Stack storage saves the pre-edge flags; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr] <= flg_q;
    end

    assign bus.flg         = flg_q;
    assign bus.cond_true   = cond_eval(bus.cond, eval_flg);
    assign bus.stack_empty = empty;
    assign bus.stack_full  = full;
    assign bus.stack_err   = err_q;

endmodule

// File: tb/tb_flag_unit.sv
// Scoreboard bench for flag_unit: stimulus pushes expected
// {flg, cond_true, stack_empty, stack_full, stack_err} and signals the monitor.
module tb_flag_unit;

    logic clk;
    logic rst;

    flag_unit_if bus ();

    flag_unit #(.STACK_DEPTH(4), .SP_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [8:0] v;
    } exp_t;

    exp_t q[$];
    event mon_ev;
    int   total = 0;
    int   bad   = 0;

`ifdef FLAG_BYPASS_EN
    localparam logic BYP_CT = 1'b1;
`else
    localparam logic BYP_CT = 1'b0;
`endif

    // Monitor: drain the scoreboard whenever stimulus signals a sample point.
    initial begin
        forever begin
            @(mon_ev);
            while (q.size() > 0) begin
                exp_t e;
                logic [8:0] act;
                e   = q.pop_front();
                act = {bus.flg, bus.cond_true, bus.stack_empty, bus.stack_full, bus.stack_err};
                total++;
                if (act !== e.v) begin
                    bad++;
                    $display("FAIL %s: got flg=%b ct=%b emp=%b full=%b err=%b, expected flg=%b ct=%b emp=%b full=%b err=%b",
                             e.name, act[8:4], act[3], act[2], act[1], act[0],
                             e.v[8:4], e.v[3], e.v[2], e.v[1], e.v[0]);
                end
            end
        end
    end

    task automatic expect_now(input string name, input logic [4:0] f, input logic ct,
                              input logic emp, input logic fu, input logic er);
        exp_t e;
        e.name = name;
        e.v    = {f, ct, emp, fu, er};
        q.push_back(e);
        ->mon_ev;
        #0;
    endtask

    task automatic drive(input logic u, input logic [4:0] a, input logic l,
                         input logic [4:0] ld, input logic ps, input logic pp,
                         input logic [3:0] c);
        bus.flg_upd       = u;
        bus.alu_flg       = a;
        bus.flg_load      = l;
        bus.flg_load_data = ld;
        bus.push          = ps;
        bus.pop           = pp;
        bus.cond          = c;
    endtask

    // One clock: drive at negedge, clear strobes after the edge, then expect.
    task automatic cyc(input string name, input logic u, input logic [4:0] a,
                       input logic l, input logic [4:0] ld, input logic ps,
                       input logic pp, input logic [3:0] c,
                       input logic [4:0] ef, input logic ect, input logic eemp,
                       input logic efull, input logic eerr);
        @(negedge clk);
        drive(u, a, l, ld, ps, pp, c);
        @(posedge clk);
        #1;
        drive(1'b0, 5'b0, 1'b0, 5'b0, 1'b0, 1'b0, c);
        expect_now(name, ef, ect, eemp, efull, eerr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 5'b0, 1'b0, 5'b0, 1'b0, 1'b0, 4'd0);
        #12;
        expect_now("reset_state", 5'b00000, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // ALU update and condition codes on 01001 (CY=1, OV=1)
        //   name            upd alu       ld  data      psh  pop  cond   flg       ct   emp  full err
        cyc("upd_cy",        1, 5'b01001, 0, 5'b00000, 0, 0, 4'd3,  5'b01001, 1, 1, 0, 0);
        cyc("cond_slt",      0, 5'b00000, 0, 5'b00000, 0, 0, 4'd11, 5'b01001, 1, 1, 0, 0);
        cyc("cond_uls",      0, 5'b00000, 0, 5'b00000, 0, 0, 4'd13, 5'b01001, 1, 1, 0, 0);
        cyc("cond_z",        0, 5'b00000, 0, 5'b00000, 0, 0, 4'd1,  5'b01001, 0, 1, 0, 0);
        cyc("cond_uhi",      0, 5'b00000, 0, 5'b00000, 0, 0, 4'd14, 5'b01001, 0, 1, 0, 0);
        cyc("cond_sge",      0, 5'b00000, 0, 5'b00000, 0, 0, 4'd12, 5'b01001, 0, 1, 0, 0);
        cyc("cond_nov",      0, 5'b00000, 0, 5'b00000, 0, 0, 4'd10, 5'b01001, 0, 1, 0, 0);
        cyc("cond_never",    0, 5'b00000, 0, 5'b00000, 0, 0, 4'd15, 5'b01001, 0, 1, 0, 0);

        // push/pop round trip
        cyc("rt_load",       0, 5'b00000, 1, 5'b10000, 0, 0, 4'd1,  5'b10000, 1, 1, 0, 0);
        cyc("rt_push",       0, 5'b00000, 0, 5'b00000, 1, 0, 4'd2,  5'b10000, 0, 0, 0, 0);
        cyc("rt_load2",      0, 5'b00000, 1, 5'b00110, 0, 0, 4'd7,  5'b00110, 1, 0, 0, 0);
        cyc("rt_pop",        0, 5'b00000, 0, 5'b00000, 0, 1, 4'd1,  5'b10000, 1, 1, 0, 0);

        // fill the stack, push+load saves the old flags
        cyc("fill1",         0, 5'b00000, 1, 5'b00001, 1, 0, 4'd9,  5'b00001, 1, 0, 0, 0);
        cyc("fill2",         0, 5'b00000, 1, 5'b00010, 1, 0, 4'd7,  5'b00010, 1, 0, 0, 0);
        cyc("fill3",         0, 5'b00000, 1, 5'b00100, 1, 0, 4'd5,  5'b00100, 1, 0, 0, 0);
        cyc("fill4_full",    0, 5'b00000, 1, 5'b01000, 1, 0, 4'd3,  5'b01000, 1, 0, 1, 0);
        cyc("push_on_full",  0, 5'b00000, 0, 5'b00000, 1, 0, 4'd4,  5'b01000, 0, 0, 1, 1);
        cyc("err_one_cycle", 0, 5'b00000, 0, 5'b00000, 0, 0, 4'd0,  5'b01000, 1, 0, 1, 0);
        cyc("pop4",          0, 5'b00000, 0, 5'b00000, 0, 1, 4'd5,  5'b00100, 1, 0, 0, 0);
        cyc("pop3",          0, 5'b00000, 0, 5'b00000, 0, 1, 4'd8,  5'b00010, 0, 0, 0, 0);
        cyc("pop2",          0, 5'b00000, 0, 5'b00000, 0, 1, 4'd10, 5'b00001, 0, 0, 0, 0);
        cyc("pop1",          0, 5'b00000, 0, 5'b00000, 0, 1, 4'd14, 5'b10000, 0, 1, 0, 0);

        // push+pop together with one entry
        cyc("pp_push",       0, 5'b00000, 0, 5'b00000, 1, 0, 4'd0,  5'b10000, 1, 0, 0, 0);
        cyc("pp_load",       0, 5'b00000, 1, 5'b00011, 0, 0, 4'd0,  5'b00011, 1, 0, 0, 0);
        cyc("push_and_pop",  0, 5'b00000, 0, 5'b00000, 1, 1, 4'd0,  5'b00011, 1, 0, 0, 1);
        cyc("pp_pop",        0, 5'b00000, 0, 5'b00000, 0, 1, 4'd0,  5'b10000, 1, 1, 0, 0);

        // push with ALU update saves old flags
        cyc("pu_clear",      0, 5'b00000, 1, 5'b00000, 0, 0, 4'd15, 5'b00000, 0, 1, 0, 0);
        cyc("push_upd",      1, 5'b11111, 0, 5'b00000, 1, 0, 4'd1,  5'b11111, 1, 0, 0, 0);
        cyc("pu_pop",        0, 5'b00000, 0, 5'b00000, 0, 1, 4'd6,  5'b00000, 1, 1, 0, 0);

        // pop on empty, load still applies
        cyc("pop_empty_ld",  0, 5'b00000, 1, 5'b00001, 0, 1, 4'd9,  5'b00001, 1, 1, 0, 1);

        // priorities: load over update, legal pop over load
        cyc("load_over_upd", 1, 5'b11111, 1, 5'b00101, 0, 0, 4'd13, 5'b00101, 0, 1, 0, 0);
        cyc("pr_push",       0, 5'b00000, 0, 5'b00000, 1, 0, 4'd0,  5'b00101, 1, 0, 0, 0);
        cyc("pop_over_load", 0, 5'b00000, 1, 5'b11111, 0, 1, 4'd0,  5'b00101, 1, 1, 0, 0);

        // same-cycle forwarding of alu_flg into cond_true
        cyc("byp_clear",     0, 5'b00000, 1, 5'b00000, 0, 0, 4'd0,  5'b00000, 1, 1, 0, 0);
        @(negedge clk);
        drive(1'b1, 5'b10000, 1'b0, 5'b0, 1'b0, 1'b0, 4'd1);
        #1;
        expect_now("bypass_same_cycle", 5'b00000, BYP_CT, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 5'b0, 1'b0, 5'b0, 1'b0, 1'b0, 4'd1);
        expect_now("bypass_after_edge", 5'b10000, 1'b1, 1'b1, 1'b0, 1'b0);

        // asynchronous reset in the middle of stack activity
        cyc("ar_load",       0, 5'b00000, 1, 5'b11000, 0, 0, 4'd0,  5'b11000, 1, 1, 0, 0);
        cyc("ar_push1",      0, 5'b00000, 0, 5'b00000, 1, 0, 4'd0,  5'b11000, 1, 0, 0, 0);
        cyc("ar_push2",      0, 5'b00000, 0, 5'b00000, 1, 0, 4'd0,  5'b11000, 1, 0, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        expect_now("async_reset", 5'b00000, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cyc("post_reset",    0, 5'b00000, 0, 5'b00000, 0, 1, 4'd0,  5'b00000, 1, 1, 0, 1);

        #5;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
